// File: rtl/sweep_pkg.sv
// Shared constants and FSM encoding for the PLA equivalence sweeper.
// Imported by the sweeper top and its range counter.
package sweep_pkg;

    localparam int N_IN_DEF   = 16;
    localparam int SETTLE_DEF = 2;
    localparam int SCW        = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        FIN
    } state_t;

endpackage

// File: rtl/sweep_range_counter.sv
// Vector counter: loads the low bound, steps on request and flags when
// it sits on the latched high bound (no reliance on overflow).
module sweep_range_counter
    import sweep_pkg::*;
#(
    parameter int N = N_IN_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         adv_i,
    input  logic [N-1:0] lo_i,
    input  logic [N-1:0] hi_i,
    output logic [N-1:0] val_o,
    output logic         last_o
);

    logic [N-1:0] val_q;
    logic [N-1:0] hi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            hi_q  <= '0;
        end else if (load_i) begin
            val_q <= lo_i;
            hi_q  <= hi_i;
        end else if (adv_i) begin
            val_q <= val_q + N'(1);
        end
    end

    assign val_o  = val_q;
    assign last_o = (val_q == hi_q);

endmodule

// File: rtl/pla_equiv_sweeper.sv
// Walks an inclusive input range into two netlists, compares their outputs
// after a settle window and reports on-set count and first mismatch.
module pla_equiv_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop_on_mismatch,
    input  logic [N_IN-1:0] range_lo,
    input  logic [N_IN-1:0] range_hi,
    output logic [N_IN-1:0] vec,
    input  logic            y_a,
    input  logic            y_b,
    output logic            busy,
    output logic            done,
    output logic            mismatch,
    output logic [N_IN-1:0] mismatch_vec,
    output logic [N_IN:0]   onset_cnt,
    output logic [N_IN:0]   vec_cnt
);

    localparam logic [SCW-1:0] RELOAD = SCW'(SETTLE - 1);
    localparam logic [SCW-1:0] S_ONE  = SCW'(1);
    localparam logic [N_IN:0]  C_ONE  = (N_IN + 1)'(1);

    state_t          state_q, state_d;
    logic [SCW-1:0]  settle_q, settle_d;
    logic            stop_q, stop_d;
    logic            mm_q, mm_d;
    logic [N_IN-1:0] mvec_q, mvec_d;
    logic [N_IN:0]   on_q, on_d;
    logic [N_IN:0]   vc_q, vc_d;
    logic            load;
    logic            adv;
    logic            last;
    logic            hit;

    sweep_range_counter #(.N(N_IN)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .adv_i  (adv),
        .lo_i   (range_lo),
        .hi_i   (range_hi),
        .val_o  (vec),
        .last_o (last)
    );

    assign hit = (y_a != y_b) && !mm_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        stop_d   = stop_q;
        mm_d     = mm_q;
        mvec_d   = mvec_q;
        on_d     = on_q;
        vc_d     = vc_q;
        load     = 1'b0;
        adv      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mm_d   = 1'b0;
                    mvec_d = '0;
                    on_d   = '0;
                    vc_d   = '0;
                    if (range_lo <= range_hi) begin
                        load     = 1'b1;
                        stop_d   = stop_on_mismatch;
                        settle_d = RELOAD;
                        state_d  = HOLD;
                    end else begin
                        state_d  = FIN;
                    end
                end
            end
            HOLD: begin
                if (settle_q == '0) state_d = SAMPLE;
                else settle_d = settle_q - S_ONE;
            end
            SAMPLE: begin
                vc_d = vc_q + C_ONE;
                if (y_a) on_d = on_q + C_ONE;
                if (hit) begin
                    mm_d   = 1'b1;
                    mvec_d = vec;
                end
                // A stop request only ends the sweep on the first mismatch.
                if (last || (hit && stop_q)) begin
                    state_d = FIN;
                end else begin
                    adv      = 1'b1;
                    settle_d = RELOAD;
                    state_d  = HOLD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            stop_q   <= 1'b0;
            mm_q     <= 1'b0;
            mvec_q   <= '0;
            on_q     <= '0;
            vc_q     <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            stop_q   <= stop_d;
            mm_q     <= mm_d;
            mvec_q   <= mvec_d;
            on_q     <= on_d;
            vc_q     <= vc_d;
        end
    end

    assign busy         = (state_q == HOLD) || (state_q == SAMPLE);
    assign done         = (state_q == FIN);
    assign mismatch     = mm_q;
    assign mismatch_vec = mvec_q;
    assign onset_cnt    = on_q;
    assign vec_cnt      = vc_q;

endmodule

// File: tb/tb_pla_equiv_sweeper.sv
// Scoreboard bench for pla_equiv_sweeper: directed and random sweeps,
// expectations from a loop-level model of the sweep rules.
module tb_pla_equiv_sweeper;

    localparam int N = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop_on_mismatch = 1'b0;
    logic [N-1:0] range_lo = '0;
    logic [N-1:0] range_hi = '0;
    logic [N-1:0] vec;
    logic         y_a;
    logic         y_b;
    logic         busy;
    logic         done;
    logic         mismatch;
    logic [N-1:0] mismatch_vec;
    logic [N:0]   onset_cnt;
    logic [N:0]   vec_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bcnt = 0;

    logic [N-1:0] g_mask = 16'h0001;
    logic         g_inv = 1'b0;
    logic         g_inj_en = 1'b0;
    logic [N-1:0] g_inj = '0;

    typedef struct {
        int done_cyc;
        int vcnt;
        int onset;
        int mm;
        int mvec;
        int last_vec;
        int busy_cyc;
    } exp_t;

    exp_t q[$];

    pla_equiv_sweeper #(.N_IN(N), .SETTLE(S)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .stop_on_mismatch (stop_on_mismatch),
        .range_lo         (range_lo),
        .range_hi         (range_hi),
        .vec              (vec),
        .y_a              (y_a),
        .y_b              (y_b),
        .busy             (busy),
        .done             (done),
        .mismatch         (mismatch),
        .mismatch_vec     (mismatch_vec),
        .onset_cnt        (onset_cnt),
        .vec_cnt          (vec_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic fn_a(input logic [N-1:0] v);
        return (^(v & g_mask)) ^ g_inv;
    endfunction

    // Netlist A and a copy of it with one optional flipped minterm.
    always_comb begin
        y_a = fn_a(vec);
        y_b = y_a ^ (g_inj_en && (vec == g_inj));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("vec_cnt", int'(vec_cnt), e.vcnt);
                    chk("onset_cnt", int'(onset_cnt), e.onset);
                    chk("mismatch", int'(mismatch), e.mm);
                    chk("mismatch_vec", int'(mismatch_vec), e.mvec);
                    chk("busy_cycles", bcnt, e.busy_cyc);
                    if (e.vcnt > 0) chk("final_vec", int'(vec), e.last_vec);
                    chk("busy_at_done", int'(busy), 0);
                end
                bcnt = 0;
            end
        end
    end

    // Issue a start on this negedge and queue the modelled outcome.
    task automatic issue(input int lo, input int hi, input logic stp);
        exp_t e;
        int   n = 0;
        int   on = 0;
        int   mm = 0;
        int   mv = 0;
        int   lastv = 0;
        logic a;
        logic b;
        if (lo <= hi) begin
            for (int v = lo; v <= hi; v++) begin
                n++;
                lastv = v;
                a = fn_a(N'(v));
                b = a ^ (g_inj_en && (N'(v) == g_inj));
                if (a) on++;
                if (a != b && mm == 0) begin
                    mm = 1;
                    mv = v;
                    if (stp) break;
                end
            end
        end
        e.done_cyc = cyc + 1 + n * (S + 1);
        e.vcnt     = n;
        e.onset    = on;
        e.mm       = mm;
        e.mvec     = mv;
        e.last_vec = lastv;
        e.busy_cyc = n * (S + 1);
        q.push_back(e);
        range_lo = N'(lo);
        range_hi = N'(hi);
        stop_on_mismatch = stp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done within %0d", bound);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic sweep(input int lo, input int hi, input logic stp);
        int n = (lo <= hi) ? hi - lo + 1 : 0;
        issue(lo, hi, stp);
        wait_done(n * (S + 1) + 20);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_vec"}, int'(vec), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_mm"}, int'(mismatch), 0);
        chk({name, "_mvec"}, int'(mismatch_vec), 0);
        chk({name, "_onset"}, int'(onset_cnt), 0);
        chk({name, "_vcnt"}, int'(vec_cnt), 0);
    endtask

    initial begin
        int lo;
        int hi;
        bit seen;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Top-of-space sweep: ends on all ones with no wrap.
        g_mask = 16'h0001; g_inv = 1'b0; g_inj_en = 1'b0;
        sweep(16'hFC00, 16'hFFFF, 1'b0);

        g_mask = 16'h0001; g_inj_en = 1'b1; g_inj = 16'h1234;
        sweep(16'h1200, 16'h12FF, 1'b0);
        sweep(16'h1200, 16'h12FF, 1'b1);

        g_inj_en = 1'b0;
        sweep(16'h0010, 16'h000F, 1'b0);

        // Single vector at all ones, with a stray start while busy.
        g_mask = 16'h0000; g_inv = 1'b1;
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        range_lo = 16'h0000;
        range_hi = 16'h00FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20);
        repeat (3) @(negedge clk);
        chk("single_vec_hold", int'(vec), 16'hFFFF);

        // Start presented during the done cycle must be ignored.
        g_mask = 16'h0005; g_inv = 1'b0;
        issue(16'h0100, 16'h0103, 1'b0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("fin_start_seen_done", int'(seen), 1);
        range_lo = 16'h0000;
        range_hi = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("fin_start_busy", int'(busy), 0);
        repeat (8) @(negedge clk);
        chk("held_vcnt", int'(vec_cnt), 4);

        // Reset in mid-sweep abandons the sweep with no done pulse.
        g_mask = 16'h0003;
        issue(16'h0000, 16'h00FF, 1'b0);
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (vec == 16'h0040) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reach_0040", int'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        q.delete();
        chk_zero("rst_mid");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        sweep(16'h0030, 16'h0050, 1'b0);

        for (int k = 0; k < 8; k++) begin
            g_mask = N'($urandom);
            g_inv = 1'($urandom);
            lo = int'($urandom_range(0, 16'hFFC0));
            hi = lo + int'($urandom_range(0, 40));
            if (k == 5) hi = lo - 1;
            g_inj_en = 1'($urandom);
            g_inj = N'(lo + int'($urandom_range(0, 40)));
            sweep(lo, hi, 1'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
